// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types: FSM state encoding and CTI burst tags.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // One-hot owner view of the arbiter state (bit0 = m0).
    function automatic logic [1:0] grant_onehot(input arb_state_t s);
        return {s == GNT1, s == GNT0};
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles of unanswered strobe and flags a timeout.
// Latency: fire is combinational from the registered count; the count updates each edge.
// Backpressure: none; a slave ack in the fire cycle wins and suppresses fire.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic s_ack,
    input  logic s_err,
    input  logic state_chg,
    output logic fire
);

    localparam int             WDW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             WD_EN  = (TIMEOUT != 0);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    logic [WDW-1:0] wd;
    logic           wd_clr;
    logic           wd_inc;

    // A response, an idle strobe or a change of owner restarts the count.
    assign wd_clr = ~stb | s_ack | s_err | state_chg;
    assign wd_inc = WD_EN & stb & ~s_ack & ~s_err;

    // Stall counter; never wraps because reaching WD_MAX forces a state change.
    always_ff @(posedge clk) begin
        if (reset || wd_clr) begin
            wd <= '0;
        end else if (wd_inc) begin
            wd <= wd + WDW'(1);
        end
    end

    assign fire = WD_EN & stb & (wd == WD_MAX) & ~s_ack;

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single-port RAM.
// Latency: grant one edge after cyc rises; slave responses pass through combinationally.
// Backpressure: the loser waits while the owner holds cyc; watchdog errors a hung slave.
module wb_ram_arbiter
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_adr,
    input  logic [31:0]   m0_dat,
    input  logic [3:0]    m0_sel,
    input  logic          m0_we,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [2:0]    m0_cti,
    input  logic [1:0]    m0_bte,
    output logic [31:0]   m0_rdt,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [AW-1:0] m1_adr,
    input  logic [31:0]   m1_dat,
    input  logic [3:0]    m1_sel,
    input  logic          m1_we,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [2:0]    m1_cti,
    input  logic [1:0]    m1_bte,
    output logic [31:0]   m1_rdt,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [AW-1:0] s_adr,
    output logic [31:0]   s_dat,
    output logic [3:0]    s_sel,
    output logic          s_we,
    output logic          s_cyc,
    output logic          s_stb,
    output logic [2:0]    s_cti,
    output logic [1:0]    s_bte,
    input  logic [31:0]   s_rdt,
    input  logic          s_ack,
    input  logic          s_err,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       sel0, sel1;
    logic       gnt_stb;
    logic       state_chg;
    logic       fire;

    // Reset masks every slave-facing request and master response immediately.
    assign sel0      = (state == GNT0) & ~reset;
    assign sel1      = (state == GNT1) & ~reset;
    assign gnt_stb   = (sel0 & m0_stb) | (sel1 & m1_stb);
    assign state_chg = (state_nxt != state);

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .stb       (gnt_stb),
        .s_ack     (s_ack),
        .s_err     (s_err),
        .state_chg (state_chg),
        .fire      (fire)
    );

    // Next owner: lock while cyc is held, hand over directly, round-robin on a tie.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) state_nxt = last ? GNT0 : GNT1;
                else if (m0_cyc)      state_nxt = GNT0;
                else if (m1_cyc)      state_nxt = GNT1;
            end
            GNT0: begin
                if (fire)           state_nxt = IDLE;
                else if (m0_cyc)    state_nxt = GNT0;
                else if (m1_cyc)    state_nxt = GNT1;
                else                state_nxt = IDLE;
            end
            GNT1: begin
                if (fire)           state_nxt = IDLE;
                else if (m1_cyc)    state_nxt = GNT1;
                else if (m0_cyc)    state_nxt = GNT0;
                else                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == GNT0)      last_nxt = 1'b0;
        else if (state_nxt == GNT1) last_nxt = 1'b1;
    end

    // State and round-robin pointer; last=1 lets m0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Slave request mux from the owner; all zero when idle or in reset.
    always_comb begin
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        s_we  = 1'b0;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_cti = '0;
        s_bte = '0;
        if (sel0) begin
            s_adr = m0_adr;
            s_dat = m0_dat;
            s_sel = m0_sel;
            s_we  = m0_we;
            s_cyc = m0_cyc & ~fire;
            s_stb = m0_stb & ~fire;
            s_cti = m0_cti;
            s_bte = m0_bte;
        end else if (sel1) begin
            s_adr = m1_adr;
            s_dat = m1_dat;
            s_sel = m1_sel;
            s_we  = m1_we;
            s_cyc = m1_cyc & ~fire;
            s_stb = m1_stb & ~fire;
            s_cti = m1_cti;
            s_bte = m1_bte;
        end
    end

    assign m0_rdt    = s_rdt;
    assign m1_rdt    = s_rdt;
    assign m0_ack    = sel0 & s_ack;
    assign m1_ack    = sel1 & s_ack;
    assign m0_err    = sel0 & (s_err | fire);
    assign m1_err    = sel1 & (s_err | fire);
    assign o_grant   = grant_onehot(state);
    assign o_timeout = fire & ~reset;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed vector table, burst/timeout sequences, random traffic.
// Latency: one check per driven cycle, sampled mid-cycle.
// Backpressure: slave responses are driven directly by the bench.
module tb_wb_ram_arbiter;
    import wb_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat, m0_rdt, m1_rdt;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [2:0]  m0_cti, m1_cti;
    logic [1:0]  m0_bte, m1_bte;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr, s_dat, s_rdt;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [1:0]  o_grant;
    logic        o_timeout;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.AW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_cti(m0_cti), .m0_bte(m0_bte),
        .m0_rdt(m0_rdt), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_cti(m1_cti), .m1_bte(m1_bte),
        .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_cti(s_cti), .s_bte(s_bte),
        .s_rdt(s_rdt), .s_ack(s_ack), .s_err(s_err),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    typedef struct packed {
        logic [1:0]  grant;
        logic        s_cyc;
        logic        s_stb;
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic        tmo;
        logic [31:0] rdt0;
        logic [31:0] rdt1;
    } obs_t;

    // Table row: {reset, cyc{m1,m0}, stb{m1,m0}, s_ack, s_err} -> {grant, s_cyc, ack, err, timeout}
    typedef struct {
        logic       rst;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic       err;
        logic [7:0] exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    obs_t obs, exp_o;

    // Reference: who owns the bus (-1 = nobody), who was granted last, stalled strobe cycles.
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_stall = 0;

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                        input logic ack, input logic err, input logic [2:0] cti0);
        int  o;
        int  nxt;
        logic f;
        @(posedge clk);
        #1;
        reset  = rst;
        m0_cyc = cyc[0]; m0_stb = stb[0];
        m1_cyc = cyc[1]; m1_stb = stb[1];
        s_ack  = ack;    s_err  = err;
        m0_cti = cti0;   m1_cti = 3'($urandom_range(0, 7));
        m0_adr = $urandom; m1_adr = $urandom;
        m0_dat = $urandom; m1_dat = $urandom;
        m0_sel = 4'($urandom_range(0, 15)); m1_sel = 4'($urandom_range(0, 15));
        m0_we  = 1'($urandom_range(0, 1));  m1_we  = 1'($urandom_range(0, 1));
        m0_bte = 2'($urandom_range(0, 3));  m1_bte = 2'($urandom_range(0, 3));
        s_rdt  = $urandom;
        #3;
        obs.grant = o_grant;  obs.s_cyc = s_cyc; obs.s_stb = s_stb;
        obs.s_adr = s_adr;    obs.s_dat = s_dat;
        obs.ack   = {m1_ack, m0_ack};
        obs.err   = {m1_err, m0_err};
        obs.tmo   = o_timeout;
        obs.rdt0  = m0_rdt;   obs.rdt1  = m1_rdt;

        o = mdl_owner;
        f = (o >= 0) && stb[o] && (mdl_stall == TMO) && !ack;
        exp_o = '0;
        exp_o.rdt0  = s_rdt;
        exp_o.rdt1  = s_rdt;
        exp_o.grant = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        if (!rst && o >= 0) begin
            exp_o.s_cyc  = cyc[o] & ~f;
            exp_o.s_stb  = stb[o] & ~f;
            exp_o.s_adr  = (o == 0) ? m0_adr : m1_adr;
            exp_o.s_dat  = (o == 0) ? m0_dat : m1_dat;
            exp_o.ack[o] = ack;
            exp_o.err[o] = err | f;
            exp_o.tmo    = f;
        end
        chk("model", 140'(obs), 140'(exp_o));

        if (rst) begin
            mdl_owner = -1; mdl_last = 1; mdl_stall = 0;
        end else begin
            if (o >= 0) begin
                if (f)               nxt = -1;
                else if (cyc[o])     nxt = o;
                else if (cyc[1 - o]) nxt = 1 - o;
                else                 nxt = -1;
            end else begin
                if (cyc == 2'b11)    nxt = (mdl_last == 1) ? 0 : 1;
                else if (cyc[0])     nxt = 0;
                else if (cyc[1])     nxt = 1;
                else                 nxt = -1;
            end
            if (o < 0 || nxt != o)          mdl_stall = 0;
            else if (stb[o] && !ack && !err) mdl_stall = mdl_stall + 1;
            else                            mdl_stall = 0;
            if (nxt >= 0) mdl_last = nxt;
            mdl_owner = nxt;
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic ack, input logic err, input logic [7:0] exp);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.exp = exp;
        return v;
    endfunction

    vec_t vt[18];

    initial begin
        logic [7:0] got;
        //                 rst cyc    stb    ack   err    grant scyc ack  err  tmo
        vt[0]  = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, {2'b00, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[1]  = mk(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, {2'b00, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[2]  = mk(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, {2'b10, 1'b1, 2'b00, 2'b00, 1'b0});
        vt[3]  = mk(1'b0, 2'b10, 2'b10, 1'b1, 1'b0, {2'b10, 1'b1, 2'b10, 2'b00, 1'b0});
        vt[4]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, {2'b10, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[5]  = mk(1'b0, 2'b11, 2'b11, 1'b0, 1'b0, {2'b00, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[6]  = mk(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, {2'b01, 1'b1, 2'b01, 2'b00, 1'b0});
        vt[7]  = mk(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, {2'b01, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[8]  = mk(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, {2'b10, 1'b1, 2'b10, 2'b00, 1'b0});
        vt[9]  = mk(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, {2'b10, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[10] = mk(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, {2'b01, 1'b1, 2'b01, 2'b00, 1'b0});
        vt[11] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, {2'b01, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[12] = mk(1'b0, 2'b11, 2'b11, 1'b0, 1'b0, {2'b00, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[13] = mk(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, {2'b10, 1'b1, 2'b10, 2'b00, 1'b0});
        vt[14] = mk(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, {2'b10, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[15] = mk(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, {2'b01, 1'b1, 2'b00, 2'b01, 1'b0});
        vt[16] = mk(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, {2'b01, 1'b0, 2'b00, 2'b00, 1'b0});
        vt[17] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, {2'b00, 1'b0, 2'b00, 2'b00, 1'b0});

        reset = 1'b1;
        m0_adr = '0; m1_adr = '0; m0_dat = '0; m1_dat = '0; m0_sel = '0; m1_sel = '0;
        m0_we = 1'b0; m1_we = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        m0_cti = CTI_CLASSIC; m1_cti = CTI_CLASSIC; m0_bte = '0; m1_bte = '0;
        s_rdt = '0; s_ack = 1'b0; s_err = 1'b0;
        repeat (2) @(posedge clk);

        // Directed table: single master, tie-break, handover, alternation, error, reset mid-cycle.
        for (int i = 0; i < 18; i++) begin
            step(vt[i].rst, vt[i].cyc, vt[i].stb, vt[i].ack, vt[i].err, CTI_CLASSIC);
            got = {obs.grant, obs.s_cyc, obs.ack, obs.err, obs.tmo};
            chk($sformatf("vec%0d", i), 140'(got), 140'(vt[i].exp));
        end

        // m0 incrementing burst while m1 waits: grant must not move mid-burst.
        step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, CTI_INCR);
        for (int b = 0; b < 4; b++) begin
            step(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, (b < 3) ? CTI_INCR : CTI_END);
            chk($sformatf("burst_grant%0d", b), 140'(obs.grant), 140'(2'b01));
            chk($sformatf("burst_ack%0d", b), 140'(obs.ack), 140'(2'b01));
        end
        step(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, CTI_CLASSIC);
        step(1'b0, 2'b10, 2'b10, 1'b1, 1'b0, CTI_CLASSIC);
        chk("burst_handover", 140'(obs.grant), 140'(2'b10));
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, CTI_CLASSIC);

        // Hung slave on m1: error and timeout pulse on the ninth stalled cycle, then idle.
        step(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, CTI_CLASSIC);
        for (int k = 0; k <= TMO; k++) begin
            step(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, CTI_CLASSIC);
            chk($sformatf("wd%0d", k), 140'({obs.s_cyc, obs.err, obs.tmo}),
                140'((k == TMO) ? 4'b0101 : 4'b1000));
        end
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, CTI_CLASSIC);
        chk("wd_idle", 140'(obs.grant), 140'(2'b00));

        // Slave ack in the would-be fire cycle: ack delivered, no error, no timeout.
        step(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, CTI_CLASSIC);
        for (int k = 0; k <= TMO; k++) begin
            step(1'b0, 2'b10, 2'b10, (k == TMO), 1'b0, CTI_CLASSIC);
        end
        chk("ack_wins", 140'({obs.s_cyc, obs.ack, obs.err, obs.tmo}), 140'(6'b110000));
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, CTI_CLASSIC);
        chk("ack_wins_hold", 140'(obs.grant), 140'(2'b10));

        // Random traffic against the reference model; some phases starve the slave.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] c, s;
            logic       a;
            c = 2'($urandom_range(0, 3));
            s = c & 2'($urandom_range(0, 3));
            a = (n % 200 < 120) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 59) == 0, c, s, a, $urandom_range(0, 24) == 0,
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
